// File: rtl/selevy_trace_monitor.sv
// rtl/selevy_trace_monitor.sv - write-trace monitor: snoops NCH write channels into a cycle-stamped FWFT FIFO
// Round-robin arbitration picks one event per cycle; losers and FIFO overflows are counted as drops.
module selevy_trace_monitor #(
    parameter int NCH        = 2,
    parameter int AW         = 5,
    parameter int DW         = 32,
    parameter int DEPTH      = 16,
    parameter int CW         = 16,
    parameter int MAX_CYCLES = 18,
    localparam int CHW       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic [NCH-1:0]    ev_valid,
    input  logic [NCH*AW-1:0] ev_addr,
    input  logic [NCH*DW-1:0] ev_data,
    input  logic              halt,
    output logic              tr_valid,
    input  logic              tr_ready,
    output logic [CW-1:0]     tr_cycle,
    output logic [CHW-1:0]    tr_ch,
    output logic [AW-1:0]     tr_addr,
    output logic [DW-1:0]     tr_data,
    output logic [CW-1:0]     cycle,
    output logic              done,
    output logic [7:0]        drop_cnt,
    output logic              overflow
);
    localparam int AWD = $clog2(DEPTH);
    localparam int PW  = AWD + 1;
    localparam int EW  = CW + CHW + AW + DW;

    logic [CW-1:0]  r_cycle;
    logic           r_done;
    logic [7:0]     r_drop;
    logic           r_ovf;
    logic [CHW-1:0] r_rr;
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [EW-1:0]  r_mem [DEPTH];

    logic           w_empty;
    logic           w_full;
    logic           w_pop;
    logic           w_push;
    logic           w_capture;
    logic           w_last;
    logic           w_gnt_any;
    logic [CHW-1:0] w_gnt;
    logic [CHW-1:0] w_idx;
    logic [CHW-1:0] w_rr_next;
    logic [31:0]    w_nvalid;
    logic [31:0]    w_lost;
    logic [31:0]    w_drop_sum;
    logic [EW-1:0]  w_entry;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AWD] != r_rd_ptr[AWD]) &&
                       (r_wr_ptr[AWD-1:0] == r_rd_ptr[AWD-1:0]);
    assign w_pop     = !w_empty && tr_ready;
    assign w_capture = !r_done;
    assign w_last    = (MAX_CYCLES != 0) && (r_cycle == CW'(MAX_CYCLES - 1));

    // Search starts at rr so no channel can be starved under sustained contention.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt     = '0;
        w_idx     = '0;
        w_nvalid  = '0;
        for (int k = 0; k < NCH; k++) begin
            w_idx = CHW'((int'(r_rr) + k) % NCH);
            if (!w_gnt_any && ev_valid[w_idx]) begin
                w_gnt_any = 1'b1;
                w_gnt     = w_idx;
            end
            if (ev_valid[k]) begin
                w_nvalid = w_nvalid + 32'd1;
            end
        end
    end

    assign w_rr_next  = CHW'((int'(w_gnt) + 1) % NCH);
    assign w_push     = w_capture && w_gnt_any && (!w_full || w_pop);
    assign w_lost     = w_capture ? (w_nvalid - 32'(w_gnt_any) + 32'(w_gnt_any && !w_push)) : '0;
    assign w_drop_sum = 32'(r_drop) + w_lost;
    assign w_entry    = {r_cycle, w_gnt, ev_addr[w_gnt*AW +: AW], ev_data[w_gnt*DW +: DW]};

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_cycle  <= '0;
            r_done   <= 1'b0;
            r_drop   <= '0;
            r_ovf    <= 1'b0;
            r_rr     <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (!r_done) begin
                if (w_last || halt) begin
                    r_done <= 1'b1;
                end
                if (!w_last) begin
                    r_cycle <= r_cycle + CW'(1);
                end
                if (w_gnt_any) begin
                    r_rr <= w_rr_next;
                end
            end
            if (w_lost != 32'd0) begin
                r_drop <= (w_drop_sum > 32'd255) ? 8'hFF : w_drop_sum[7:0];
            end
            if (w_capture && w_gnt_any && !w_push) begin
                r_ovf <= 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AWD-1:0]] <= w_entry;
        end
    end

    assign tr_valid = !w_empty;
    assign {tr_cycle, tr_ch, tr_addr, tr_data} = r_mem[r_rd_ptr[AWD-1:0]];
    assign cycle    = r_cycle;
    assign done     = r_done;
    assign drop_cnt = r_drop;
    assign overflow = r_ovf;
endmodule

// File: tb/tb_selevy_trace_monitor.sv
// tb/tb_selevy_trace_monitor.sv - self-checking bench for selevy_trace_monitor
module tb_selevy_trace_monitor;
    localparam int NCH = 2, AW = 5, DW = 32, DEPTH = 16, CW = 16, MAXC = 18, CHW = 1;

    logic              CLK;
    logic              reset;
    logic [NCH-1:0]    ev_valid;
    logic [NCH*AW-1:0] ev_addr;
    logic [NCH*DW-1:0] ev_data;
    logic              halt;
    logic              tr_valid;
    logic              tr_ready;
    logic [CW-1:0]     tr_cycle;
    logic [CHW-1:0]    tr_ch;
    logic [AW-1:0]     tr_addr;
    logic [DW-1:0]     tr_data;
    logic [CW-1:0]     cycle;
    logic              done;
    logic [7:0]        drop_cnt;
    logic              overflow;

    int total = 0;
    int bad   = 0;

    selevy_trace_monitor #(
        .NCH(NCH), .AW(AW), .DW(DW), .DEPTH(DEPTH), .CW(CW), .MAX_CYCLES(MAXC)
    ) dut (
        .CLK(CLK), .reset(reset), .ev_valid(ev_valid), .ev_addr(ev_addr), .ev_data(ev_data),
        .halt(halt), .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_cycle(tr_cycle),
        .tr_ch(tr_ch), .tr_addr(tr_addr), .tr_data(tr_data), .cycle(cycle), .done(done),
        .drop_cnt(drop_cnt), .overflow(overflow)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: a queue of trace entries plus scalar run state, updated once per clock.
    typedef struct packed {
        logic [CW-1:0]  cyc;
        logic [CHW-1:0] ch;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  data;
    } ent_t;

    ent_t q[$];
    int   m_cycle, m_drop, m_rr;
    bit   m_done, m_ovf;
    bit   m_live = 0;

    always @(posedge CLK) begin
        bit   pop;
        int   g;
        int   lost;
        ent_t e;
        if (reset) begin
            q.delete();
            m_cycle = 0; m_drop = 0; m_rr = 0; m_done = 0; m_ovf = 0; m_live = 1;
        end else if (m_live) begin
            pop  = (q.size() > 0) && tr_ready;
            lost = 0;
            g    = -1;
            if (!m_done) begin
                for (int k = 0; k < NCH; k++)
                    if (g < 0 && ((ev_valid >> ((m_rr + k) % NCH)) & 1) != 0) g = (m_rr + k) % NCH;
                for (int k = 0; k < NCH; k++)
                    if (k != g && ((ev_valid >> k) & 1) != 0) lost++;
            end
            if (pop) void'(q.pop_front());
            if (g >= 0) begin
                if (q.size() < DEPTH) begin
                    e.cyc  = CW'(m_cycle);
                    e.ch   = CHW'(g);
                    e.addr = AW'(ev_addr >> (g * AW));
                    e.data = DW'(ev_data >> (g * DW));
                    q.push_back(e);
                end else begin
                    lost++;
                    m_ovf = 1;
                end
                m_rr = (g + 1) % NCH;
            end
            m_drop = (m_drop + lost > 255) ? 255 : m_drop + lost;
            if (!m_done) begin
                if (MAXC != 0 && m_cycle == MAXC - 1) m_done = 1;
                else m_cycle = (m_cycle + 1) % (1 << CW);
                if (halt) m_done = 1;
            end
        end
    end

    always @(negedge CLK) begin
        if (m_live) begin
            chk("m_valid", 64'(tr_valid), 64'(q.size() > 0));
            if (q.size() > 0) begin
                chk("m_head_cycle", 64'(tr_cycle), 64'(q[0].cyc));
                chk("m_head_ch", 64'(tr_ch), 64'(q[0].ch));
                chk("m_head_addr", 64'(tr_addr), 64'(q[0].addr));
                chk("m_head_data", 64'(tr_data), 64'(q[0].data));
            end
            chk("m_cycle", 64'(cycle), 64'(m_cycle));
            chk("m_done", 64'(done), 64'(m_done));
            chk("m_drop", 64'(drop_cnt), 64'(m_drop));
            chk("m_overflow", 64'(overflow), 64'(m_ovf));
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_ev(input logic [1:0] v, input logic [4:0] a1, input logic [4:0] a0,
                          input logic [31:0] d1, input logic [31:0] d0);
        ev_valid = v;
        ev_addr  = {a1, a0};
        ev_data  = {d1, d0};
    endtask

    task automatic do_reset();
        set_ev(2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
        halt     = 1'b0;
        tr_ready = 1'b0;
        reset    = 1'b1;
        tick();
        reset    = 1'b0;
    endtask

    initial begin
        logic [1:0] v;
        reset = 1'b1; halt = 1'b0; tr_ready = 1'b0;
        set_ev(2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
        tick();
        do_reset();
        chk("rst_valid", 64'(tr_valid), 64'd0);
        chk("rst_cycle", 64'(cycle), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);

        // single event at cycle 2
        tick(); tick();
        set_ev(2'b01, 5'd0, 5'd3, 32'd0, 32'hA5);
        tick();
        set_ev(2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
        chk("t1_valid", 64'(tr_valid), 64'd1);
        chk("t1_cycle", 64'(tr_cycle), 64'd2);
        chk("t1_ch", 64'(tr_ch), 64'd0);
        chk("t1_addr", 64'(tr_addr), 64'd3);
        chk("t1_data", 64'(tr_data), 64'hA5);

        // two-channel contention, round-robin
        do_reset();
        set_ev(2'b11, 5'd7, 5'd4, 32'h200, 32'h100);
        tick(); tick();
        set_ev(2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
        chk("t2_drop", 64'(drop_cnt), 64'd2);
        chk("t2_first_ch", 64'(tr_ch), 64'd0);
        chk("t2_first_cycle", 64'(tr_cycle), 64'd0);
        chk("t2_first_addr", 64'(tr_addr), 64'd4);
        tr_ready = 1'b1;
        tick();
        tr_ready = 1'b0;
        chk("t2_second_ch", 64'(tr_ch), 64'd1);
        chk("t2_second_cycle", 64'(tr_cycle), 64'd1);
        chk("t2_second_data", 64'(tr_data), 64'h200);

        // 17 events into a 16-deep FIFO, then drain in order
        do_reset();
        for (int i = 0; i < 17; i++) begin
            set_ev(2'b01, 5'd0, 5'(i), 32'd0, 32'h1000 + 32'(i));
            tick();
        end
        set_ev(2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
        chk("t3_drop", 64'(drop_cnt), 64'd1);
        chk("t3_overflow", 64'(overflow), 64'd1);
        tr_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("t3_drain_cycle", 64'(tr_cycle), 64'(i));
            tick();
        end
        tr_ready = 1'b0;
        chk("t3_empty", 64'(tr_valid), 64'd0);
        chk("t3_done", 64'(done), 64'd1);
        chk("t3_cycle_hold", 64'(cycle), 64'd17);

        // full FIFO with simultaneous pop accepts the event
        do_reset();
        for (int i = 0; i < 16; i++) begin
            set_ev(2'b01, 5'd0, 5'(i), 32'd0, 32'(i));
            tick();
        end
        chk("t4_full_ovf", 64'(overflow), 64'd0);
        set_ev(2'b01, 5'd0, 5'd16, 32'd0, 32'd16);
        tr_ready = 1'b1;
        tick();
        tr_ready = 1'b0;
        chk("t4_pushpop_ovf", 64'(overflow), 64'd0);
        chk("t4_pushpop_drop", 64'(drop_cnt), 64'd0);
        chk("t4_head_cycle", 64'(tr_cycle), 64'd1);
        tick();
        set_ev(2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
        chk("t4_still_full_drop", 64'(drop_cnt), 64'd1);
        chk("t4_still_full_ovf", 64'(overflow), 64'd1);

        // cycle limit
        do_reset();
        for (int i = 0; i < 17; i++) tick();
        chk("t5_pre_cycle", 64'(cycle), 64'd17);
        chk("t5_pre_done", 64'(done), 64'd0);
        tick();
        chk("t5_done", 64'(done), 64'd1);
        chk("t5_cycle_hold", 64'(cycle), 64'd17);
        set_ev(2'b11, 5'd1, 5'd2, 32'd3, 32'd4);
        tick(); tick();
        set_ev(2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
        chk("t5_ignored_drop", 64'(drop_cnt), 64'd0);
        chk("t5_ignored_valid", 64'(tr_valid), 64'd0);
        chk("t5_cycle_final", 64'(cycle), 64'd17);

        // halt with an event on the same cycle
        do_reset();
        for (int i = 0; i < 5; i++) tick();
        set_ev(2'b10, 5'd9, 5'd0, 32'h55, 32'd0);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        set_ev(2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
        chk("t6_done", 64'(done), 64'd1);
        chk("t6_valid", 64'(tr_valid), 64'd1);
        chk("t6_ch", 64'(tr_ch), 64'd1);
        chk("t6_cycle_stamp", 64'(tr_cycle), 64'd5);
        chk("t6_addr", 64'(tr_addr), 64'd9);
        chk("t6_data", 64'(tr_data), 64'h55);
        chk("t6_cycle", 64'(cycle), 64'd6);
        set_ev(2'b01, 5'd0, 5'd1, 32'd0, 32'd1);
        tick();
        set_ev(2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
        chk("t6_after_drop", 64'(drop_cnt), 64'd0);
        do_reset();
        chk("t6_rst_valid", 64'(tr_valid), 64'd0);
        chk("t6_rst_cycle", 64'(cycle), 64'd0);
        chk("t6_rst_done", 64'(done), 64'd0);

        // mixed traffic with intermittent reader, checked by the model
        do_reset();
        for (int i = 0; i < 30; i++) begin
            v = 2'((i * 5 + 1) % 4);
            set_ev(v, 5'(i + 10), 5'(i), 32'h0B00 + 32'(i), 32'h0A00 + 32'(i));
            tr_ready = (i % 3) != 0;
            tick();
        end
        set_ev(2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
        tr_ready = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("t7_drained", 64'(tr_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
